axi_frame_gate: RTL
===================

Name: axi_frame_gate

Overview:
- Ingress stage ahead of the channelizer input FIFO.
- Takes a free-running, non-stallable sample stream (valid only, no ready) and cuts it into fixed-length frames.
- Marks the last sample of each frame with tlast.
- Drops whole frames, never partial ones, when the downstream FIFO reports almost_full at a frame boundary, so FFT frame alignment survives backpressure.
- Counts dropped frames and flags lost samples.

Parameters:
- DATA_WIDTH, 32, sample width in bits.
- FRAME_WIDTH, 12, width of frame_len_m1; maximum frame length is 2^FRAME_WIDTH.
- CNT_WIDTH, 16, width of drop_cnt and of the optional sequence number.

Ports:
- clk  in  1  clock.
- sync_reset  in  1  asynchronous, active-high reset; asserts immediately, deasserts synchronously to clk externally.
- frame_len_m1  in  FRAME_WIDTH  frame length minus one; sampled only at a frame boundary.
- s_axis_tvalid  in  1  input sample strobe; cannot be stalled.
- s_axis_tdata  in  DATA_WIDTH  input sample.
- almost_full  in  1  almost_full from the downstream FIFO.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tlast  out  1  last sample of a frame.
- m_axis_tready  in  1  downstream ready.
- drop_cnt  out  CNT_WIDTH  frames dropped; saturating.
- overflow  out  1  sticky: an accepted-frame sample was lost.

Behaviour:
- Reset values (async): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, drop_cnt=0, overflow=0, sample counter=0, state=BOUNDARY, latched length=0.
- Sample counter: advances on every s_axis_tvalid in every state. Wraps to 0 after reaching the latched length, so frame alignment follows the source, not the output.
- Length latch: frame_len_m1 is latched when the counter is 0 and s_axis_tvalid=1. frame_len_m1=0 gives 1-sample frames, each with tlast=1.
- FSM states: BOUNDARY, PASS, DROP.
  - BOUNDARY, s_axis_tvalid=1: decision on the current almost_full.
    - almost_full=0: sample goes to the output register; go to PASS, or stay in BOUNDARY if the frame is 1 sample.
    - almost_full=1: sample discarded; drop_cnt increments; go to DROP, or stay in BOUNDARY if the frame is 1 sample.
  - PASS: each valid sample goes to the output register. Return to BOUNDARY after the sample with counter==latched length.
  - DROP: each valid sample is discarded. Return to BOUNDARY after the sample with counter==latched length.
- Output register: single stage, latency 1 cycle from s_axis_tvalid to m_axis_tvalid.
  - m_axis_tlast=1 when the registered sample had counter==latched length.
  - m_axis_tvalid clears when m_axis_tready=1 and no new sample is loaded in the same cycle.
  - Simultaneous tready=1 and a new sample: the register reloads, giving a back-to-back transfer.
- Overflow: a pass-frame sample arrives while m_axis_tvalid=1 and m_axis_tready=0.
  - The new sample is discarded and the held sample is kept.
  - overflow sets and stays set until reset.
  - The counter still advances, so a lost last sample means that frame has no tlast.
- almost_full changes mid-frame are ignored; gating happens only at boundaries.
- drop_cnt saturates at all ones.
- Reset asserted mid-frame: everything returns to reset values. The first valid sample after release starts a new frame.

Optional Feature:
- Macro: FRAME_GATE_TUSER_EN.
- When defined:
  - Adds output port m_axis_tuser [CNT_WIDTH-1:0], carrying the source frame sequence number.
  - The sequence number increments at every frame boundary, including dropped frames, and wraps modulo 2^CNT_WIDTH.
  - It is registered alongside tdata, so downstream can detect gaps; reset value 0.
- When undefined: no port, no sequence counter. All other behaviour is identical.

Decomposition:
- Shared package:
  - FSM state encoding (BOUNDARY=2'd0, PASS=2'd1, DROP=2'd2).
  - A saturating-increment function shared with other channelizer counters.
- Sub-module: axi_out_reg, a one-stage output register with valid/ready/tlast (and tuser under the macro).
- Gate FSM and counters stay in the top level.

Test Plan:
- frame_len_m1=7, almost_full=0, tready=1, samples 0..23 continuous -> 24 outputs, 1-cycle latency, tlast on data 7, 15 and 23; drop_cnt=0.
- frame_len_m1=7, almost_full=1 during the boundary cycle of the second frame only -> data 8..15 absent, tlast on 7 and 23, drop_cnt=1.
- almost_full rises at the third sample of a frame -> whole frame passes, drop_cnt unchanged; the next boundary drops.
- tready=0 for 3 cycles mid-frame with continuous input -> held sample kept, 3 samples lost, overflow=1; counter alignment intact, so the next frame's tlast lands on the correct data.
- sync_reset pulsed at sample 5 of a frame -> outputs cleared immediately; the next frame starts at the first post-reset sample; frame_len_m1 changed before the next boundary takes effect only there.
- With FRAME_GATE_TUSER_EN defined: drop frame 1 of frames 0..3 -> tuser sequence 0, 2, 3; drop_cnt at max value plus one more drop -> stays 0xFFFF.

Source files
------------

// File: rtl/axi_frame_gate_pkg.sv
// Shared definitions for the frame gate: gate FSM state encoding and the
// saturating-increment helper used by the channelizer event counters.
package axi_frame_gate_pkg;

  typedef enum logic [1:0] {
    BOUNDARY = 2'd0,
    PASS     = 2'd1,
    DROP     = 2'd2
  } gate_state_e;

  // Increments value but sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] satInc(input logic [31:0] value, input int width);
    logic [31:0] maxVal;
    maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= maxVal) ? maxVal : value + 32'd1;
  endfunction

endpackage

// File: rtl/axi_frame_gate_out_reg.sv
// Single-stage AXI-Stream output register with valid/ready/tlast.
// Carries a tuser field when FRAME_GATE_TUSER_EN is defined.
module axi_out_reg #(
  parameter int DATA_WIDTH = 32
`ifdef FRAME_GATE_TUSER_EN
  , parameter int USER_WIDTH = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
`ifdef FRAME_GATE_TUSER_EN
  input  logic [USER_WIDTH-1:0] user_i,
  output logic [USER_WIDTH-1:0] user_o,
`endif
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  blocked_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  // A held sample that downstream is refusing; the producer must not load over it.
  assign blocked_o = valid_q && !ready_i;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign last_o    = last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef FRAME_GATE_TUSER_EN
  logic [USER_WIDTH-1:0] user_q;

  assign user_o = user_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      user_q <= '0;
    end else if (load_i) begin
      user_q <= user_i;
    end
  end
`endif

endmodule

// File: rtl/axi_frame_gate.sv
// Frame gate: cuts a non-stallable sample stream into fixed-length frames and drops
// whole frames at boundaries under almost_full. FRAME_GATE_TUSER_EN adds a frame sequence tuser.
module axi_frame_gate #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WIDTH = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [FRAME_WIDTH-1:0] frame_len_m1,
  input  logic                   s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   almost_full,
  output logic                   m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  output logic                   overflow
`ifdef FRAME_GATE_TUSER_EN
  ,
  output logic [CNT_WIDTH-1:0]   m_axis_tuser
`endif
);

  import axi_frame_gate_pkg::*;

  gate_state_e            state_q;
  logic [FRAME_WIDTH-1:0] cnt_q;
  logic [FRAME_WIDTH-1:0] cnt_d;
  logic [FRAME_WIDTH-1:0] len_q;
  logic [FRAME_WIDTH-1:0] curLen;
  logic [CNT_WIDTH-1:0]   drop_cnt_q;
  logic [CNT_WIDTH-1:0]   drop_cnt_d;
  logic                   overflow_q;
  logic                   isLast;
  logic                   passSample;
  logic                   dropStart;
  logic                   outBlocked;
  logic                   loadOut;

  // The first sample of a frame must already use the length it latches.
  assign curLen     = (cnt_q == '0) ? frame_len_m1 : len_q;
  assign isLast     = (cnt_q == curLen);
  assign passSample = s_axis_tvalid &&
                      (((state_q == BOUNDARY) && !almost_full) || (state_q == PASS));
  assign dropStart  = s_axis_tvalid && (state_q == BOUNDARY) && almost_full;
  assign loadOut    = passSample && !outBlocked;

  assign cnt_d      = s_axis_tvalid ? (isLast ? '0 : cnt_q + FRAME_WIDTH'(1)) : cnt_q;
  assign drop_cnt_d = dropStart ? CNT_WIDTH'(satInc(32'(drop_cnt_q), CNT_WIDTH)) : drop_cnt_q;

  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q    <= BOUNDARY;
      cnt_q      <= '0;
      len_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (s_axis_tvalid && (cnt_q == '0)) begin
        len_q <= frame_len_m1;
      end
      if (passSample && outBlocked) begin
        overflow_q <= 1'b1;
      end
      if (s_axis_tvalid) begin
        case (state_q)
          BOUNDARY: if (!isLast) state_q <= almost_full ? DROP : PASS;
          PASS:     if (isLast) state_q <= BOUNDARY;
          DROP:     if (isLast) state_q <= BOUNDARY;
          default:  state_q <= BOUNDARY;
        endcase
      end
    end
  end

`ifdef FRAME_GATE_TUSER_EN
  logic [CNT_WIDTH-1:0] seq_q;

  // Source frame number: advances on every frame end, dropped frames included.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      seq_q <= '0;
    end else if (s_axis_tvalid && isLast) begin
      seq_q <= seq_q + CNT_WIDTH'(1);
    end
  end
`endif

  axi_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
`ifdef FRAME_GATE_TUSER_EN
    , .USER_WIDTH(CNT_WIDTH)
`endif
  ) u_out_reg (
    .clk_i    (clk),
    .rst_i    (sync_reset),
    .load_i   (loadOut),
    .data_i   (s_axis_tdata),
    .last_i   (isLast),
`ifdef FRAME_GATE_TUSER_EN
    .user_i   (seq_q),
    .user_o   (m_axis_tuser),
`endif
    .ready_i  (m_axis_tready),
    .valid_o  (m_axis_tvalid),
    .data_o   (m_axis_tdata),
    .last_o   (m_axis_tlast),
    .blocked_o(outBlocked)
  );

endmodule
